reset_vector_seq: RTL and testbench

//  CPU-side consumer of the stretched power-on reset. Once reset is released it runs
//  the 7-cycle 6502 reset sequence: two dummy PC reads, then three stack reads that

---
 rtl/cpu_pkg.sv | 19 +
 rtl/reset_vector_seq.sv | 99 +++++++++
 tb/tb_reset_vector_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: reset-sequence state encoding and fixed bus addresses.
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_HOLD = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_DONE = 4'd8
   } state_t;

   localparam logic [15:0] RESET_VEC  = 16'hFFFC;
   localparam logic [7:0]  STACK_PAGE = 8'h01;

endpackage

// File: rtl/reset_vector_seq.sv
// 6502-style reset sequence: dummy PC reads, three stack-read SP decrements, vector fetch.
// Delivers start PC, SP and I flag to the core and raises pc_valid when done.
//
// state   | meaning
// --------+---------------------------------------------------------
// HOLD    | waiting for rst_req low on an enabled cycle
// T0, T1  | dummy reads at PC_INIT
// T2..T4  | stack reads at {01,SP}; SP decrements on leaving
// T5      | vector low byte read at VEC_ADDR
// T6      | vector high byte read at VEC_ADDR+1
// DONE    | start PC valid, addr follows pc_out
module reset_vector_seq
   import cpu_pkg::*;
#(
   parameter logic [15:0] VEC_ADDR = RESET_VEC,
   parameter logic [7:0]  SP_INIT  = 8'h00,
   parameter logic [15:0] PC_INIT  = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_enable,
   input  logic        rst_req,
   input  logic [7:0]  data_in,
   output logic [15:0] addr,
   output logic        rw,
   output logic        busy,
   output logic [15:0] pc_out,
   output logic [7:0]  sp_out,
   output logic        i_flag,
   output logic        pc_valid
);

   state_t state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_HOLD;
         busy     <= 1'b1;
         pc_out   <= 16'h0000;
         sp_out   <= SP_INIT;
         i_flag   <= 1'b1;
         pc_valid <= 1'b0;
      end else if (rst_req) begin
         // restart wins over advancement, even on the T6 capture edge
         state    <= ST_HOLD;
         busy     <= 1'b1;
         i_flag   <= 1'b1;
         pc_valid <= 1'b0;
      end else if (clk_enable) begin
         i_flag <= 1'b1;
         case (state)
            ST_HOLD: begin
               state  <= ST_T0;
               sp_out <= SP_INIT;
            end
            ST_T0: state <= ST_T1;
            ST_T1: state <= ST_T2;
            ST_T2: begin
               state  <= ST_T3;
               sp_out <= sp_out - 8'd1;
            end
            ST_T3: begin
               state  <= ST_T4;
               sp_out <= sp_out - 8'd1;
            end
            ST_T4: begin
               state  <= ST_T5;
               sp_out <= sp_out - 8'd1;
            end
            ST_T5: begin
               state       <= ST_T6;
               pc_out[7:0] <= data_in;
            end
            ST_T6: begin
               state        <= ST_DONE;
               pc_out[15:8] <= data_in;
               pc_valid     <= 1'b1;
               busy         <= 1'b0;
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_HOLD;
         endcase
      end
   end

   always_comb begin
      addr = PC_INIT;
      case (state)
         ST_T2, ST_T3, ST_T4: addr = {STACK_PAGE, sp_out};
         ST_T5:               addr = VEC_ADDR;
         ST_T6:               addr = VEC_ADDR + 16'd1;
         ST_DONE:             addr = pc_out;
         default:             addr = PC_INIT;
      endcase
   end

   assign rw = 1'b1;

endmodule

// File: tb/tb_reset_vector_seq.sv
// Bench for reset_vector_seq: expected bus addresses and start PCs are queued when a run
// is launched and popped as the sequencer steps through its enabled cycles.
module tb_reset_vector_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_enable;
   logic        rst_req;
   logic [7:0]  data_in;
   logic [15:0] addr;
   logic        rw;
   logic        busy;
   logic [15:0] pc_out;
   logic [7:0]  sp_out;
   logic        i_flag;
   logic        pc_valid;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] addr_q[$];
   logic [15:0] pc_q[$];
   logic [7:0]  mem_lo = 8'h00;
   logic [7:0]  mem_hi = 8'h00;

   always #5 clk = ~clk;

   reset_vector_seq dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clk_enable (clk_enable),
      .rst_req    (rst_req),
      .data_in    (data_in),
      .addr       (addr),
      .rw         (rw),
      .busy       (busy),
      .pc_out     (pc_out),
      .sp_out     (sp_out),
      .i_flag     (i_flag),
      .pc_valid   (pc_valid)
   );

   // bus model: vector bytes at FFFC/FFFD, filler elsewhere
   always_comb begin
      data_in = 8'h5A;
      if (addr == 16'hFFFC)      data_in = mem_lo;
      else if (addr == 16'hFFFD) data_in = mem_hi;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input logic [7:0] lo, input logic [7:0] hi);
      mem_lo = lo;
      mem_hi = hi;
      addr_q.push_back(16'h0000);
      addr_q.push_back(16'h0000);
      addr_q.push_back(16'h0100);
      addr_q.push_back(16'h01FF);
      addr_q.push_back(16'h01FE);
      addr_q.push_back(16'hFFFC);
      addr_q.push_back(16'hFFFD);
      pc_q.push_back({hi, lo});
   endtask

   task automatic leave_hold(input int period);
      for (int k = 0; k < period; k++) begin
         clk_enable = (k == period - 1);
         chk("hold_addr", addr, 16'h0000);
         chk("hold_pvld", pc_valid, 1'b0);
         tick();
      end
      clk_enable = 1'b0;
      chk("sp_t0", sp_out, 8'h00);
   endtask

   task automatic step(input int period);
      logic [15:0] exp;
      if (addr_q.size() == 0) begin
         chk("sb_underflow", addr_q.size(), 1);
         return;
      end
      exp = addr_q.pop_front();
      for (int k = 0; k < period; k++) begin
         clk_enable = (k == period - 1);
         chk("seq_addr", addr, exp);
         chk("seq_rw", rw, 1'b1);
         chk("seq_pvld_busy", {pc_valid, busy}, 2'b01);
         tick();
      end
      clk_enable = 1'b0;
   endtask

   task automatic finish_run();
      logic [15:0] exp_pc;
      if (pc_q.size() == 0) begin
         chk("pc_underflow", pc_q.size(), 1);
         return;
      end
      exp_pc = pc_q.pop_front();
      chk("done_pvld", pc_valid, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_pc", pc_out, exp_pc);
      chk("done_sp", sp_out, 8'hFD);
      chk("done_iflag", i_flag, 1'b1);
      clk_enable = 1'b1;
      for (int k = 0; k < 2; k++) begin
         chk("done_addr", addr, exp_pc);
         tick();
      end
      clk_enable = 1'b0;
      chk("done_hold_pc", pc_out, exp_pc);
      chk("done_hold_sp", sp_out, 8'hFD);
      chk("done_hold_pvld", pc_valid, 1'b1);
   endtask

   task automatic run_seq(input int period, input logic [7:0] lo, input logic [7:0] hi);
      push_run(lo, hi);
      leave_hold(period);
      for (int s = 0; s < 7; s++) step(period);
      finish_run();
   endtask

   // rst_req for two clocks: first with enable low, then with enable high
   task automatic restart(input logic [15:0] keep_pc);
      rst_req    = 1'b1;
      clk_enable = 1'b0;
      tick();
      chk("rs_pvld", pc_valid, 1'b0);
      chk("rs_busy", busy, 1'b1);
      chk("rs_iflag", i_flag, 1'b1);
      chk("rs_addr", addr, 16'h0000);
      chk("rs_pc_kept", pc_out, keep_pc);
      clk_enable = 1'b1;
      tick();
      chk("rs_stay_addr", addr, 16'h0000);
      chk("rs_stay_busy", busy, 1'b1);
      rst_req    = 1'b0;
      clk_enable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      rst_req    = 1'b0;
      clk_enable = 1'b1;
      for (int k = 0; k < 3; k++) tick();

      // 1: reset values
      chk("rst_addr", addr, 16'h0000);
      chk("rst_rw", rw, 1'b1);
      chk("rst_busy", busy, 1'b1);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_sp", sp_out, 8'h00);
      chk("rst_iflag", i_flag, 1'b1);
      chk("rst_pvld", pc_valid, 1'b0);
      reset_n    = 1'b1;
      clk_enable = 1'b0;
      tick();
      chk("idle_no_enable", busy, 1'b1);

      // 2: full sequence, enable every clock
      run_seq(1, 8'h34, 8'h12);

      // 3: enable one clock in four
      restart(16'h1234);
      run_seq(4, 8'h34, 8'h12);

      // 4: restart while in T5 with enable high: no low-byte capture
      restart(16'h1234);
      push_run(8'h99, 8'h88);
      leave_hold(1);
      for (int s = 0; s < 5; s++) step(1);
      chk("t5_addr", addr, 16'hFFFC);
      rst_req    = 1'b1;
      clk_enable = 1'b1;
      tick();
      rst_req    = 1'b0;
      clk_enable = 1'b0;
      chk("t5_abort_pvld", pc_valid, 1'b0);
      chk("t5_abort_busy", busy, 1'b1);
      chk("t5_abort_addr", addr, 16'h0000);
      chk("t5_abort_pc", pc_out, 16'h1234);
      addr_q.delete();
      pc_q.delete();
      run_seq(1, 8'h78, 8'h56);

      // 5: restart on the T6 edge: low byte already taken, high byte not
      restart(16'h5678);
      push_run(8'h11, 8'h22);
      leave_hold(1);
      for (int s = 0; s < 6; s++) step(1);
      chk("t6_addr", addr, 16'hFFFD);
      rst_req    = 1'b1;
      clk_enable = 1'b1;
      tick();
      rst_req    = 1'b0;
      clk_enable = 1'b0;
      chk("t6_abort_pc", pc_out, 16'h5611);
      chk("t6_abort_pvld", pc_valid, 1'b0);
      chk("t6_abort_busy", busy, 1'b1);
      addr_q.delete();
      pc_q.delete();

      // 6: complete, restart from DONE, fetch a new vector
      run_seq(1, 8'h34, 8'h12);
      restart(16'h1234);
      run_seq(2, 8'hCD, 8'hAB);

      chk("sb_drained", addr_q.size() + pc_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
